// File: rtl/mod_n_sequence_checker_if.sv
// rtl/mod_n_sequence_checker_if.sv - observed counter bus plus checker status outputs
interface mod_n_sequence_checker_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] d_in;
  logic             clear_err;
  logic             locked;
  logic             err_pulse;
  logic             oor_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;

  modport master (
    output in_valid, d_in, clear_err,
    input  locked, err_pulse, oor_pulse, err_count, wrap_count
  );

  modport slave (
    input  in_valid, d_in, clear_err,
    output locked, err_pulse, oor_pulse, err_count, wrap_count
  );
endinterface

// File: rtl/mod_n_sequence_checker.sv
// rtl/mod_n_sequence_checker.sv - locks onto a mod-N wrap sequence and flags skips, repeats and out-of-range codes
module mod_n_sequence_checker #(
  parameter int MOD      = 5,
  parameter int WIDTH    = 3,
  parameter int LOCK_LEN = 3,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mod_n_sequence_checker_if.slave bus
);
  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

  localparam int                MW       = $clog2(LOCK_LEN + 1);
  localparam logic [WIDTH-1:0]  LAST     = WIDTH'(MOD - 1);
  localparam logic [MW-1:0]     LOCK_TGT = MW'(LOCK_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n, exp_val;
  logic [MW-1:0]    match_cnt, match_n;
  logic             err_q, err_n, oor_q, oor_n;
  logic [CNT_W-1:0] err_count, errc_n, wrap_count, wrap_n;
  logic             in_range, hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNLOCKED;
      prev       <= '0;
      match_cnt  <= '0;
      err_q      <= 1'b0;
      oor_q      <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      match_cnt  <= match_n;
      err_q      <= err_n;
      oor_q      <= oor_n;
      err_count  <= errc_n;
      wrap_count <= wrap_n;
    end
  end

  always_comb begin
    exp_val  = (prev == LAST) ? '0 : prev + WIDTH'(1);
    in_range = (bus.d_in <= LAST);
    hit      = (bus.d_in == exp_val);
    state_n  = state;
    prev_n   = prev;
    match_n  = match_cnt;
    err_n    = 1'b0;
    oor_n    = 1'b0;
    wrap_n   = wrap_count;
    if (bus.in_valid) begin
      if (!in_range) begin
        // Any out-of-range code drops all the way back to acquisition.
        oor_n   = 1'b1;
        err_n   = (state == LOCKED);
        state_n = UNLOCKED;
      end else begin
        prev_n = bus.d_in;
        case (state)
          UNLOCKED: begin
            match_n = '0;
            state_n = LOCKING;
          end
          LOCKING: begin
            if (hit && match_cnt == LOCK_TGT - MW'(1)) begin
              match_n = '0;
              state_n = LOCKED;
            end else if (hit) begin
              match_n = match_cnt + MW'(1);
            end else begin
              match_n = '0;
            end
          end
          LOCKED: begin
            if (hit) begin
              if (prev == LAST) wrap_n = wrap_count + CNT_W'(1);
            end else begin
              err_n   = 1'b1;
              match_n = '0;
              state_n = LOCKING;
            end
          end
          default: state_n = UNLOCKED;
        endcase
      end
    end
    // Clear takes priority over a coincident error increment.
    if (bus.clear_err)                      errc_n = '0;
    else if (err_n && err_count != CNT_MAX) errc_n = err_count + CNT_W'(1);
    else                                    errc_n = err_count;
  end

  assign bus.locked     = (state == LOCKED);
  assign bus.err_pulse  = err_q;
  assign bus.oor_pulse  = oor_q;
  assign bus.err_count  = err_count;
  assign bus.wrap_count = wrap_count;
endmodule

// File: tb/tb_mod_n_sequence_checker.sv
// tb/tb_mod_n_sequence_checker.sv - directed and randomized checks of mod_n_sequence_checker against a behavioural model
module tb_mod_n_sequence_checker;
  localparam int MOD = 5, WIDTH = 3, LOCK_LEN = 3, CNT_W = 8;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mod_n_sequence_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  mod_n_sequence_checker #(.MOD(MOD), .WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: an anchor value plus a run length of correct modular successors.
  bit m_have, m_locked, m_err, m_oor;
  int m_prev, m_run, m_errc, m_wrap;
  int cur;

  task automatic model(input bit v, input int d, input bit clr, input bit rst);
    bit err_ev;
    err_ev = 0;
    m_err  = 0;
    m_oor  = 0;
    if (rst) begin
      m_have = 0; m_locked = 0; m_prev = 0; m_run = 0; m_errc = 0; m_wrap = 0;
      return;
    end
    if (v) begin
      if (d >= MOD) begin
        m_oor = 1; err_ev = m_locked; m_have = 0; m_locked = 0;
      end else if (!m_have) begin
        m_have = 1; m_prev = d; m_run = 0;
      end else begin
        if (d == (m_prev + 1) % MOD) begin
          if (m_locked && m_prev == MOD - 1) m_wrap = (m_wrap + 1) % (1 << CNT_W);
          m_run++;
          if (m_run >= LOCK_LEN) m_locked = 1;
        end else begin
          err_ev = m_locked; m_locked = 0; m_run = 0;
        end
        m_prev = d;
      end
    end
    m_err = err_ev;
    if (clr) m_errc = 0;
    else if (err_ev && m_errc < (1 << CNT_W) - 1) m_errc++;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input bit v, input int d, input bit clr = 0, input bit rst = 0);
    bus.in_valid  = v;
    bus.d_in      = WIDTH'(d);
    bus.clear_err = clr;
    reset         = rst;
    @(posedge clk);
    #1;
    model(v, d, clr, rst);
    if (v && !rst) cur = d;
    chk("locked",     int'(bus.locked),     int'(m_locked));
    chk("err_pulse",  int'(bus.err_pulse),  int'(m_err));
    chk("oor_pulse",  int'(bus.oor_pulse),  int'(m_oor));
    chk("err_count",  int'(bus.err_count),  m_errc);
    chk("wrap_count", int'(bus.wrap_count), m_wrap);
  endtask

  // Repeat the last value (an error while locked) then relock with LOCK_LEN successors.
  task automatic err_relock(input bit clr = 0);
    step(1, cur, clr);
    for (int k = 0; k < LOCK_LEN; k++) step(1, (cur + 1) % MOD);
  endtask

  initial begin
    bus.in_valid = 0; bus.d_in = '0; bus.clear_err = 0; reset = 1;
    cur = 0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_locked", int'(bus.locked), 0);
    chk("reset_errc",   int'(bus.err_count), 0);

    // 1: acquire and lock on 0,1,2,3 then wrap
    step(1, 0); step(1, 1); step(1, 2);
    chk("t1_not_yet_locked", int'(bus.locked), 0);
    step(1, 3);
    chk("t1_locked_at_3", int'(bus.locked), 1);
    step(1, 4); step(1, 0);
    chk("t1_wrap", int'(bus.wrap_count), 1);
    step(1, 1);
    chk("t1_errc", int'(bus.err_count), 0);

    // 2: 2,3 correct then 1 is a skip-back
    step(1, 2); step(1, 3); step(1, 1);
    chk("t2_err_pulse", int'(bus.err_pulse), 1);
    chk("t2_errc", int'(bus.err_count), 1);
    chk("t2_unlocked", int'(bus.locked), 0);
    step(1, 2); step(1, 3);
    chk("t2_not_relocked", int'(bus.locked), 0);
    step(1, 4);
    chk("t2_relocked", int'(bus.locked), 1);

    // 3: out-of-range while locked
    step(1, 6);
    chk("t3_err_pulse", int'(bus.err_pulse), 1);
    chk("t3_oor_pulse", int'(bus.oor_pulse), 1);
    chk("t3_unlocked", int'(bus.locked), 0);
    chk("t3_errc", int'(bus.err_count), 2);

    // 4: saturation, then clear coincident with an error
    step(1, 0); step(1, 1); step(1, 2); step(1, 3);
    for (int i = 0; i < 300; i++) err_relock();
    chk("t4_saturated", int'(bus.err_count), 255);
    step(1, cur, 1);
    chk("t4_clear_wins", int'(bus.err_count), 0);
    chk("t4_pulse_kept", int'(bus.err_pulse), 1);
    for (int k = 0; k < LOCK_LEN; k++) step(1, (cur + 1) % MOD);

    // 5: idle gap while locked
    for (int i = 0; i < 10; i++) step(0, $urandom_range(0, 7));
    chk("t5_still_locked", int'(bus.locked), 1);
    step(1, (cur + 1) % MOD);
    chk("t5_no_err", int'(bus.err_pulse), 0);

    // 6: build err_count=4 and wrap_count=7, then reset
    step(0, 0, 0, 1);
    step(1, 0); step(1, 1); step(1, 2); step(1, 3);
    for (int i = 0; i < 35; i++) step(1, (cur + 1) % MOD);
    for (int i = 0; i < 4; i++) err_relock();
    chk("t6_errc", int'(bus.err_count), 4);
    chk("t6_wrap", int'(bus.wrap_count), 7);
    step(1, (cur + 1) % MOD, 0, 1);
    chk("t6_rst_locked", int'(bus.locked), 0);
    chk("t6_rst_errc", int'(bus.err_count), 0);
    chk("t6_rst_wrap", int'(bus.wrap_count), 0);

    // Randomized stream biased towards correct successors
    for (int i = 0; i < 3000; i++) begin
      int r, d;
      r = int'($urandom_range(0, 99));
      if (r < 75)      d = (m_prev + 1) % MOD;
      else if (r < 85) d = m_prev;
      else             d = int'($urandom_range(0, 7));
      step($urandom_range(0, 9) != 0, d, $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
